// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller:
// source count, register offsets and the invalid claim id.
package irq_ctrl_pkg;

    localparam int NSRC = 6;

    typedef enum logic [2:0] {
        REG_CTRL  = 3'd0,
        REG_MASK  = 3'd1,
        REG_MODE  = 3'd2,
        REG_PEND  = 3'd3,
        REG_CLAIM = 3'd4,
        REG_EOI   = 3'd5,
        REG_INSVC = 3'd6,
        REG_RSVD  = 3'd7
    } reg_e;

    localparam logic [2:0] CLAIM_NONE = 3'd7;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit wins.
// Reports valid, its index and a one-hot copy.
module irq_prio_enc #(
    parameter int NSRC = irq_ctrl_pkg::NSRC
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [2:0]      idx,
    output logic [NSRC-1:0] onehot
);

    always_comb begin
        valid  = |req;
        idx    = irq_ctrl_pkg::CLAIM_NONE;
        onehot = '0;
        // Walk downwards so the last hit is the lowest index.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = 3'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with edge/level sources,
// claim/EOI handshake and priority nesting toward CP0 HWInt.
module irq_ctrl #(
    parameter int NSRC = irq_ctrl_pkg::NSRC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] irq_src,
    output logic            IRQ,
    output logic [NSRC-1:0] HWInt
);

    import irq_ctrl_pkg::*;

    reg_e            sel;
    logic [NSRC-1:0] wdat;

    logic            gen;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] insvc;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] src_qq;

    logic            gen_d;
    logic [NSRC-1:0] mask_d;
    logic [NSRC-1:0] mode_d;
    logic [NSRC-1:0] pend_w;
    logic [NSRC-1:0] pend_d;
    logic [NSRC-1:0] insvc_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] blocked;
    logic [NSRC-1:0] eligible;
    logic            blk_acc;

    logic            best_vld;
    logic [2:0]      best_id;
    logic [NSRC-1:0] best_oh;

    logic            unused_ok;

    assign sel       = reg_e'(Addr[4:2]);
    assign wdat      = Din[NSRC-1:0];
    assign rise      = src_q & ~src_qq;
    assign unused_ok = ^{Addr[31:5], Din[31:NSRC]};

    // A source is blocked while it or any higher-priority one is in service.
    always_comb begin
        blk_acc = 1'b0;
        blocked = '0;
        for (int i = 0; i < NSRC; i++) begin
            blk_acc    = blk_acc | insvc[i];
            blocked[i] = blk_acc;
        end
    end

    assign eligible = pend & mask & ~blocked;

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_prio (
        .req    (eligible),
        .valid  (best_vld),
        .idx    (best_id),
        .onehot (best_oh)
    );

    assign HWInt = gen ? best_oh : '0;
    assign IRQ   = |HWInt;

    always_comb begin
        gen_d   = gen;
        mask_d  = mask;
        mode_d  = mode;
        pend_w  = pend;
        insvc_d = insvc;
        if (WE) begin
            unique case (sel)
                REG_CTRL:  gen_d  = Din[0];
                REG_MASK:  mask_d = wdat;
                REG_MODE: begin
                    mode_d = wdat;
                    pend_w = pend & ~(mode ^ wdat);
                end
                REG_PEND:  pend_w = pend & ~(wdat & mode);
                REG_CLAIM: begin
                    if (best_vld) begin
                        insvc_d = insvc | best_oh;
                        pend_w  = pend & ~(best_oh & mode);
                    end
                end
                REG_EOI: begin
                    if (Din[2:0] < 3'(NSRC)) begin
                        insvc_d = insvc & ~(NSRC'(1) << Din[2:0]);
                    end
                end
                REG_INSVC: ;
                REG_RSVD:  ;
            endcase
        end
        // New edges override any clear in the same cycle; level bits track the line.
        pend_d = (mode_d & (pend_w | rise)) | (~mode_d & src_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gen    <= 1'b0;
            mask   <= '0;
            mode   <= '0;
            pend   <= '0;
            insvc  <= '0;
            src_q  <= '0;
            src_qq <= '0;
        end else begin
            gen    <= gen_d;
            mask   <= mask_d;
            mode   <= mode_d;
            pend   <= pend_d;
            insvc  <= insvc_d;
            src_q  <= irq_src;
            src_qq <= src_q;
        end
    end

    always_comb begin
        Dout = '0;
        unique case (sel)
            REG_CTRL:  Dout = {31'b0, gen};
            REG_MASK:  Dout = 32'(mask);
            REG_MODE:  Dout = 32'(mode);
            REG_PEND:  Dout = 32'(pend);
            REG_CLAIM: Dout = {best_vld, 28'b0, best_id};
            REG_INSVC: Dout = 32'(insvc);
            REG_EOI:   Dout = '0;
            REG_RSVD:  Dout = '0;
        endcase
    end

endmodule
